rx_frame_buf_ctrl: RTL

//  Frame-commit FIFO controller around one internal dual-port RAM (ram_2port_rx, port A write, port B read).

---
 rtl/rx_frame_buf_ctrl_pkg.sv | 12 +
 rtl/rx_frame_buf_ctrl_if.sv | 22 ++
 rtl/rx_frame_buf_ctrl_ram.sv | 32 +++
 rtl/rx_frame_buf_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rx_frame_buf_ctrl_pkg.sv
// Shared types and constants for the RX frame-commit buffer controller.
package rx_frame_buf_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DROP  = 2'd2
    } wr_state_e;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/rx_frame_buf_ctrl_if.sv
// Decoder-side word stream in, DMA-side ready/valid stream out.
interface rx_frame_buf_ctrl_if #(
    parameter int unsigned DWIDTH = 32
);
    logic [DWIDTH-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic [DWIDTH-1:0] out_data;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  out_data, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output out_data, out_last, out_valid
    );
endinterface

// File: rtl/rx_frame_buf_ctrl_ram.sv
// Dual-port RAM, single clock: port A writes, port B reads with a registered output.
module ram_2port_rx #(
    parameter int unsigned DWIDTH = 33,
    parameter int unsigned AWIDTH = 9
) (
    input  logic              clka,
    input  logic              ena,
    input  logic              wea,
    input  logic [AWIDTH-1:0] addra,
    input  logic [DWIDTH-1:0] dia,
    input  logic              enb,
    input  logic              web,
    input  logic [AWIDTH-1:0] addrb,
    input  logic [DWIDTH-1:0] dib,
    output logic [DWIDTH-1:0] dob
);
    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clka) begin
        if (ena && wea) begin
            mem[addra] <= dia;
        end
        if (enb) begin
            if (web) begin
                mem[addrb] <= dib;
            end
            dob <= mem[addrb];
        end
    end
endmodule

// File: rtl/rx_frame_buf_ctrl.sv
// Frame-commit FIFO: words become readable only once their frame's last word is stored;
// frames that do not fit are discarded whole.
module rx_frame_buf_ctrl
    import rx_frame_buf_ctrl_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 9,
    parameter int unsigned CWIDTH = 16
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  flush,
    rx_frame_buf_ctrl_if.slave    bus,
    output logic [AWIDTH:0]       fill_level,
    output logic                  overflow,
    output logic [CWIDTH-1:0]     drop_count
);
    localparam int unsigned PW = AWIDTH + 1;
    localparam int unsigned EW = DWIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(1) << AWIDTH;

    wr_state_e       state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            word, full, avail;
    logic            ram_we, drop, issue, pop;
    logic [EW-1:0]   ram_dob, head;
    logic [EW-1:0]   skid_q [SKID_DEPTH];
    logic [EW-1:0]   skid_d [SKID_DEPTH];
    logic [EW-1:0]   l0, l1;
    logic [1:0]      skid_cnt_q, skid_cnt_d, occ;
    logic            inflight_q;

    assign word  = enable && bus.in_valid;
    assign full  = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign avail = cm_ptr_q != rd_ptr_q;

    // Write FSM: tentative writes advance wr_ptr, in_last publishes them via cm_ptr.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        ram_we   = 1'b0;
        drop     = 1'b0;
        case (state_q)
            S_IDLE, S_WRITE: begin
                if (word) begin
                    if (full) begin
                        drop     = 1'b1;
                        wr_ptr_d = cm_ptr_q;
                        state_d  = bus.in_last ? S_IDLE : S_DROP;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (bus.in_last) begin
                            cm_ptr_d = wr_ptr_q + PW'(1);
                            state_d  = S_IDLE;
                        end else begin
                            state_d  = S_WRITE;
                        end
                    end
                end
            end
            S_DROP: begin
                if (word && bus.in_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The RAM output register acts as the landing stage; it counts towards skid occupancy.
    assign occ   = skid_cnt_q + {1'b0, inflight_q};
    assign issue = enable && avail && (occ < 2'(SKID_DEPTH));
    assign rd_ptr_d = rd_ptr_q + PW'(issue);

    always_comb begin
        head = '0;
        if (skid_cnt_q != 2'd0) begin
            head = skid_q[0];
        end else if (inflight_q) begin
            head = ram_dob;
        end
    end

    assign bus.out_valid = (skid_cnt_q != 2'd0) || inflight_q;
    assign bus.out_data  = head[DWIDTH-1:0];
    assign bus.out_last  = head[DWIDTH];
    assign pop           = bus.out_valid && bus.out_ready;

    // Ordered view of {skid entries, landing word}; a pop shifts the view by one.
    always_comb begin
        l0 = (skid_cnt_q >= 2'd1) ? skid_q[0] : ram_dob;
        l1 = (skid_cnt_q >= 2'd2) ? skid_q[1] : ram_dob;
        skid_d[0]  = pop ? l1 : l0;
        skid_d[1]  = pop ? ram_dob : l1;
        skid_cnt_d = occ - 2'(pop);
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            skid_cnt_q <= '0;
            inflight_q <= 1'b0;
            fill_level <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                skid_q[i] <= '0;
            end
        end else if (flush) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            skid_cnt_q <= '0;
            inflight_q <= 1'b0;
            fill_level <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            skid_cnt_q <= skid_cnt_d;
            inflight_q <= issue;
            fill_level <= cm_ptr_d - rd_ptr_d;
            overflow   <= drop;
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + CWIDTH'(1);
            end
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                skid_q[i] <= skid_d[i];
            end
        end
    end

    ram_2port_rx #(
        .DWIDTH (EW),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clka  (clka),
        .ena   (ram_we && !flush),
        .wea   (1'b1),
        .addra (wr_ptr_q[AWIDTH-1:0]),
        .dia   ({bus.in_last, bus.in_data}),
        .enb   (issue && !flush),
        .web   (1'b0),
        .addrb (rd_ptr_q[AWIDTH-1:0]),
        .dib   ('0),
        .dob   (ram_dob)
    );

endmodule
